wb_burst_master: RTL and testbench

- Wishbone pipelined-mode initiator (B4 pipelined, single clock). Converts simple command / write-data / read-data streams into Wishbone cycles with stall and ack handling.
- Drives one port of a Wishbone slave, for example one port of the team's dual_port_ram.
- Supports incrementing bursts of 1..2^LEN_W beats within one cyc assertion.
- Enforces an ack timeout and reports completion status per command.

---
 rtl/wb_burst_master_if.sv | 60 ++++++
 rtl/wb_burst_master.sv | 188 ++++++++++++++++++
 tb/tb_wb_burst_master.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_master_if
//  Purpose  : Bundles the command, write-data, read-data, status and
//             Wishbone pipelined bus signals of wb_burst_master.
//  Modports : master - view taken by wb_burst_master
//             slave  - view taken by the environment (command source and
//                      Wishbone slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    // Command stream
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    // Write-data stream
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_valid_i;
    logic              wr_ready_o;
    // Read-data stream and completion status
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              done_o;
    logic              err_o;
    logic              busy_o;
    // Wishbone B4 pipelined initiator side
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [DATA_W-1:0] wb_data_i;
    logic              wb_ack_i;
    logic              wb_stall_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
        input  wr_data_i, wr_valid_i,
        input  wb_data_i, wb_ack_i, wb_stall_i,
        output cmd_ready_o, wr_ready_o,
        output rd_data_o, rd_valid_o, done_o, err_o, busy_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
        output wr_data_i, wr_valid_i,
        output wb_data_i, wb_ack_i, wb_stall_i,
        input  cmd_ready_o, wr_ready_o,
        input  rd_data_o, rd_valid_o, done_o, err_o, busy_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_master
//  Purpose  : Wishbone B4 pipelined initiator. Turns one command (we, addr,
//             beats-1) plus a write-data or read-data stream into a single
//             cyc assertion carrying an incrementing burst, handling stall,
//             ack counting and an ack timeout.
//  Ports    : clk  - system clock
//             rst  - asynchronous reset, active-high
//             bus  - wb_burst_master_if.master (command / write / read /
//                    status streams and the Wishbone initiator signals)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_burst_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int ADDR_STEP = 4,
    parameter int TIMEOUT   = 20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wb_burst_master_if.master  bus
);

    localparam int CNT_W = LEN_W + 1;                 // holds 0..2^LEN_W
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_cmdReady;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_beats;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_acked;
    logic [CNT_W-1:0]   r_outstanding;
    logic [TMR_W-1:0]   r_timer;
    logic               r_cyc;
    logic               r_stb;
    logic [DATA_W-1:0]  r_rdData;
    logic               r_rdValid;
    logic               r_done;
    logic               r_err;

    logic w_issue;
    logic w_ackEff;
    logic w_wrReady;
    logic w_load;
    logic w_lastIssue;
    logic w_allAcked;
    logic w_timeout;

    // A beat leaves on the edge where stb is high and the slave is not stalling.
    assign w_issue    = r_stb & ~bus.wb_stall_i;
    // Acks only count while beats are actually outstanding on this cycle.
    assign w_ackEff   = bus.wb_ack_i & r_cyc & (r_outstanding != '0);
    // For writes r_stb doubles as "one beat loaded, not yet issued", so
    // issued + stb is the number of beats already pulled from the stream.
    assign w_wrReady  = (r_state == S_ISSUE) & r_we &
                        ((r_issued + CNT_W'(r_stb)) < r_beats) &
                        (~r_stb | ~bus.wb_stall_i);
    assign w_load     = bus.wr_valid_i & w_wrReady;
    assign w_lastIssue = w_issue & ((r_issued + CNT_W'(1)) == r_beats);
    assign w_allAcked  = w_ackEff & ((r_acked + CNT_W'(1)) == r_beats);
    assign w_timeout   = r_cyc & ~bus.wb_ack_i & (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cmdReady    <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_beats       <= '0;
            r_issued      <= '0;
            r_acked       <= '0;
            r_outstanding <= '0;
            r_timer       <= '0;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_rdData      <= '0;
            r_rdValid     <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rdValid <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            if (w_ackEff & ~r_we) begin
                r_rdValid <= 1'b1;
                r_rdData  <= bus.wb_data_i;
            end

            case (r_state)
                S_IDLE: begin
                    r_cmdReady <= 1'b1;
                    if (bus.cmd_valid_i & r_cmdReady) begin
                        r_cmdReady    <= 1'b0;
                        r_we          <= bus.cmd_we_i;
                        r_addr        <= bus.cmd_addr_i;
                        r_beats       <= {1'b0, bus.cmd_len_i} + CNT_W'(1);
                        r_issued      <= '0;
                        r_acked       <= '0;
                        r_outstanding <= '0;
                        r_timer       <= '0;
                        r_cyc         <= 1'b1;
                        // Reads strobe immediately; writes wait for data.
                        r_stb         <= ~bus.cmd_we_i;
                        r_state       <= S_ISSUE;
                    end
                end

                S_ISSUE, S_WAIT_ACK: begin
                    r_issued      <= r_issued + CNT_W'(w_issue);
                    r_acked       <= r_acked + CNT_W'(w_ackEff);
                    r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_ackEff);
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_W'(ADDR_STEP);
                    end
                    // Any ack, even an ignored one, restarts the timeout.
                    if (bus.wb_ack_i) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end

                    // A write beat issuing without a replacement leaves a bubble.
                    if (w_load) begin
                        r_data <= bus.wr_data_i;
                        r_stb  <= 1'b1;
                    end else if (w_issue & (r_we | w_lastIssue)) begin
                        r_stb  <= 1'b0;
                    end

                    if (w_lastIssue) begin
                        r_state <= S_WAIT_ACK;
                    end

                    // Completion and abort share the teardown; they are
                    // mutually exclusive since one needs an ack and one none.
                    if (w_allAcked | w_timeout) begin
                        r_cyc         <= 1'b0;
                        r_stb         <= 1'b0;
                        r_done        <= 1'b1;
                        r_err         <= w_timeout;
                        r_issued      <= '0;
                        r_acked       <= '0;
                        r_outstanding <= '0;
                        r_timer       <= '0;
                        r_state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_cmdReady <= 1'b1;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = r_cmdReady;
    assign bus.wr_ready_o  = w_wrReady;
    assign bus.rd_data_o   = r_rdData;
    assign bus.rd_valid_o  = r_rdValid;
    assign bus.done_o      = r_done;
    assign bus.err_o       = r_err;
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.wb_cyc_o    = r_cyc;
    assign bus.wb_stb_o    = r_stb;
    assign bus.wb_we_o     = r_we;
    assign bus.wb_addr_o   = r_addr;
    assign bus.wb_data_o   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_burst_master
//  Purpose  : Self-checking bench for wb_burst_master: directed scenarios
//             followed by randomized commands against a reactive Wishbone
//             slave and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_burst_master;
    localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 4, ADDR_STEP = 4, TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    wb_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .ADDR_STEP(ADDR_STEP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave memory and knobs ----------------
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] memRd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    typedef struct packed { logic [31:0] addr; logic we; int due; } beat_t;
    beat_t pendQ[$];
    int  stallPct = 0, ackDelayMax = 0, wrGapPct = 0;
    int  forceStallBeat = -1, forceStallLen = 0, forceCnt = 0, slvBeat = 0;
    bit  mute = 0, strayAck = 0;
    int  gapAfterBeats = 0, gapLen = 0, gapCnt = 0, wrConsumed = 0;
    logic [31:0] wrFeed[$];
    bit  wrTaken = 0;
    int  cycleNo = 0;

    // ---------------- reference model state ----------------
    bit          mActive = 0, mDone = 0, mErr = 0, mRdValid = 0, readyArmed = 0;
    logic [31:0] mRdData, mAddr;
    bit          mWe;
    int          mBeats, mIssued, mAcked, mLoaded, mTimer;
    logic [31:0] wrExpQ[$];
    bit          pStbStall = 0, pWe;
    logic [31:0] pAddr, pData;
    logic [31:0] issueLog[$], rdLog[$];
    int          cycHigh = 0, doneCnt = 0;
    bit          lastErr = 0, bubbleSeen = 0;

    bit          acc, iss, ld, ackE, eStb, nDone, nRdValid;
    logic [31:0] ea, wexp;

    // ---------------- slave driver + per-cycle compare ----------------
    initial begin : p_cycle
        forever begin
            @(negedge clk);
            cycleNo++;
            // write-data source
            if (wrTaken && wrFeed.size() > 0) begin
                void'(wrFeed.pop_front());
                wrConsumed++;
                if (wrConsumed == gapAfterBeats) gapCnt = gapLen;
            end
            if (gapCnt > 0) begin
                gapCnt--;
                bus.wr_valid_i = 1'b0;
            end else if (wrFeed.size() > 0 && $urandom_range(99) >= wrGapPct) begin
                bus.wr_valid_i = 1'b1;
                bus.wr_data_i  = wrFeed[0];
            end else begin
                bus.wr_valid_i = 1'b0;
            end
            // slave ack
            bus.wb_ack_i  = 1'b0;
            bus.wb_data_i = $urandom;
            if (strayAck) begin
                bus.wb_ack_i = 1'b1;
                strayAck = 0;
            end else if (!mute && pendQ.size() > 0 && pendQ[0].due <= cycleNo) begin
                bus.wb_ack_i = 1'b1;
                if (!pendQ[0].we) bus.wb_data_i = memRd(pendQ[0].addr);
                void'(pendQ.pop_front());
            end
            // slave stall
            if (bus.wb_stb_o && slvBeat == forceStallBeat && forceCnt < forceStallLen) begin
                bus.wb_stall_i = 1'b1;
                forceCnt++;
            end else begin
                bus.wb_stall_i = ($urandom_range(99) < stallPct);
            end

            #1;
            if (rst) begin
                check("reset_outs", {bus.wb_cyc_o, bus.wb_stb_o, bus.done_o, bus.err_o, bus.rd_valid_o,
                                     bus.busy_o, bus.cmd_ready_o, bus.wr_ready_o}, 8'h00);
                mActive = 0; mDone = 0; mRdValid = 0; readyArmed = 0; pStbStall = 0;
                wrTaken = 0; pendQ.delete(); wrExpQ.delete(); slvBeat = 0; forceCnt = 0;
            end else begin
                // ---- compare current outputs against the model ----
                eStb = mActive && (mWe ? (mLoaded > mIssued) : (mIssued < mBeats));
                check("wb_cyc", bus.wb_cyc_o, mActive);
                check("wb_stb", bus.wb_stb_o, eStb);
                check("done", bus.done_o, mDone);
                if (mDone) check("err", bus.err_o, mErr);
                check("rd_valid", bus.rd_valid_o, mRdValid);
                if (mRdValid) check("rd_data", bus.rd_data_o, mRdData);
                check("busy", bus.busy_o, mActive || mDone);
                if (readyArmed) check("cmd_ready", bus.cmd_ready_o, !(mActive || mDone));
                check("wr_ready", bus.wr_ready_o,
                      mActive && mWe && (mLoaded < mBeats) && (!eStb || !bus.wb_stall_i));
                if (pStbStall && mActive) begin
                    check("hold_addr", bus.wb_addr_o, pAddr);
                    check("hold_we", bus.wb_we_o, pWe);
                    if (pWe) check("hold_data", bus.wb_data_o, pData);
                end
                if (bus.rd_valid_o) rdLog.push_back(bus.rd_data_o);
                if (bus.done_o) begin doneCnt++; lastErr = bus.err_o; end
                if (bus.wb_cyc_o && !bus.wb_stb_o && mIssued > 0 && mIssued < mBeats) bubbleSeen = 1;
                pStbStall = bus.wb_stb_o && bus.wb_stall_i;
                pAddr = bus.wb_addr_o; pData = bus.wb_data_o; pWe = bus.wb_we_o;

                // ---- events on the coming edge ----
                acc  = bus.cmd_valid_i && bus.cmd_ready_o;
                iss  = bus.wb_stb_o && !bus.wb_stall_i;
                ld   = bus.wr_valid_i && bus.wr_ready_o;
                ackE = bus.wb_ack_i && mActive && (mIssued - mAcked > 0);
                nDone = 0; nRdValid = 0;
                if (mActive) cycHigh++;
                if (iss) begin
                    pendQ.push_back('{addr: bus.wb_addr_o, we: bus.wb_we_o,
                                      due: cycleNo + 1 + $urandom_range(ackDelayMax)});
                    if (bus.wb_we_o) mem[bus.wb_addr_o] = bus.wb_data_o;
                    slvBeat++;
                    issueLog.push_back(bus.wb_addr_o);
                    if (!mActive || mIssued >= mBeats) begin
                        check("extra_issue", 1'b1, 1'b0);
                    end else begin
                        ea = mAddr + 32'(mIssued * ADDR_STEP);
                        check("wb_addr", bus.wb_addr_o, ea);
                        check("wb_we", bus.wb_we_o, mWe);
                        if (mWe) begin
                            if (wrExpQ.size() == 0) check("wb_data_none", 1'b1, 1'b0);
                            else begin
                                wexp = wrExpQ.pop_front();
                                check("wb_data", bus.wb_data_o, wexp);
                            end
                        end
                    end
                end
                if (ld) begin
                    wrExpQ.push_back(bus.wr_data_i);
                    mLoaded++;
                end
                wrTaken = ld;
                if (ackE) begin
                    if (!mWe) begin
                        nRdValid = 1;
                        mRdData = memRd(mAddr + 32'(mAcked * ADDR_STEP));
                    end
                    mAcked++;
                end
                if (mActive) mTimer = bus.wb_ack_i ? 0 : mTimer + 1;
                if (iss && mActive) mIssued++;
                if (ackE && mAcked == mBeats) begin
                    mActive = 0; nDone = 1; mErr = 0;
                end else if (mActive && mTimer == TIMEOUT) begin
                    mActive = 0; nDone = 1; mErr = 1;
                end
                mDone = nDone; mRdValid = nRdValid;
                if (acc) begin
                    mActive = 1; mWe = bus.cmd_we_i; mAddr = bus.cmd_addr_i;
                    mBeats = int'(bus.cmd_len_i) + 1;
                    mIssued = 0; mAcked = 0; mLoaded = 0; mTimer = 0;
                    wrExpQ.delete(); issueLog.delete(); rdLog.delete();
                    cycHigh = 0; bubbleSeen = 0;
                end
                if (!bus.wb_cyc_o) begin
                    pendQ.delete(); slvBeat = 0; forceCnt = 0;
                end
                readyArmed = 1;
            end
        end
    end

    // ---------------- command helpers ----------------
    task automatic issueCmd(input bit we, input logic [31:0] addr, input int len);
        bit got;
        got = 0;
        wrConsumed = 0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_len_i   = LEN_W'(len);
        for (int i = 0; i < 50 && !got; i++) begin
            #2;
            if (bus.cmd_ready_o) got = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check("cmd_accepted", got, 1'b1);
    endtask

    task automatic runCmd(input bit we, input logic [31:0] addr, input int len);
        int d0;
        d0 = doneCnt;
        issueCmd(we, addr, len);
        for (int i = 0; i < 300 && doneCnt == d0; i++) @(negedge clk);
        check("cmd_done_seen", doneCnt > d0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] expAddr[4];
    initial begin : p_main
        bus.cmd_valid_i = 0; bus.cmd_we_i = 0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0;
        bus.wr_valid_i = 0; bus.wr_data_i = '0;
        bus.wb_ack_i = 0; bus.wb_stall_i = 0; bus.wb_data_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write
        wrFeed = {32'hDEADBEEF};
        runCmd(1'b1, 32'h0, 0);
        check("t1_beats", issueLog.size(), 1);
        check("t1_err", lastErr, 1'b0);
        check("t1_mem", memRd(32'h0), 32'hDEADBEEF);

        // single read
        mem[32'h400] = 32'hCAFEBABE;
        runCmd(1'b0, 32'h400, 0);
        check("t2_rd_count", rdLog.size(), 1);
        if (rdLog.size() > 0) check("t2_rd_data", rdLog[0], 32'hCAFEBABE);
        check("t2_err", lastErr, 1'b0);

        // 4-beat read, second beat stalled for 2 cycles
        forceStallBeat = 1; forceStallLen = 2;
        runCmd(1'b0, 32'h8, 3);
        forceStallBeat = -1;
        expAddr = '{32'h8, 32'hC, 32'h10, 32'h14};
        check("t3_beats", issueLog.size(), 4);
        for (int i = 0; i < 4 && i < issueLog.size(); i++) check("t3_addr", issueLog[i], expAddr[i]);
        check("t3_rd_count", rdLog.size(), 4);
        check("t3_err", lastErr, 1'b0);

        // 3-beat write with a 2-cycle gap after the first beat
        wrFeed = {32'h11111111, 32'h22222222, 32'h33333333};
        gapAfterBeats = 1; gapLen = 2;
        runCmd(1'b1, 32'h100, 2);
        gapAfterBeats = 0;
        check("t4_beats", issueLog.size(), 3);
        check("t4_bubble", bubbleSeen, 1'b1);
        check("t4_mem0", memRd(32'h100), 32'h11111111);
        check("t4_mem1", memRd(32'h104), 32'h22222222);
        check("t4_mem2", memRd(32'h108), 32'h33333333);
        check("t4_err", lastErr, 1'b0);

        // slave never acks -> timeout abort, then a late ack
        mute = 1;
        runCmd(1'b0, 32'h200, 0);
        mute = 0;
        check("t5_err", lastErr, 1'b1);
        check("t5_cyc_cycles", cycHigh, TIMEOUT);
        strayAck = 1;
        repeat (4) @(negedge clk);
        check("t5_no_rd", rdLog.size(), 0);

        // reset in the middle of a 4-beat read
        ackDelayMax = 2;
        issueCmd(1'b0, 32'h300, 3);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_cyc", bus.wb_cyc_o, 1'b0);
        check("t6_stb", bus.wb_stb_o, 1'b0);
        check("t6_busy", bus.busy_o, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2 check("t6_cmd_ready", bus.cmd_ready_o, 1'b1);
        runCmd(1'b0, 32'h404, 0);
        check("t6_rd_count", rdLog.size(), 1);
        check("t6_err", lastErr, 1'b0);

        // randomized commands, first one crossing the address wrap
        stallPct = 25; ackDelayMax = 3; wrGapPct = 20;
        for (int n = 0; n < 40; n++) begin
            bit          we;
            logic [31:0] a;
            int          len;
            we  = $urandom_range(1);
            a   = {$urandom_range(32'h3FF), 2'b00};
            len = $urandom_range(15);
            if (n == 0) begin we = 0; a = 32'hFFFF_FFF8; len = 3; end
            if (n == 1) begin we = 1; a = 32'hFFFF_FFFC; len = 2; end
            wrFeed.delete();
            if (we) for (int j = 0; j <= len; j++) wrFeed.push_back($urandom);
            runCmd(we, a, len);
            check("rand_err", lastErr, 1'b0);
            check("rand_beats", issueLog.size(), len + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
